// File: rtl/fifo_stack_sched_if.sv
// Bundle between fifo_stack_sched and its environment: the two write requesters,
// the byte transmitter and the shared fifo_stack instance.
interface fifo_stack_sched_if #(
    parameter int STACK_WIDTH = 8,
    parameter int LEVEL_W     = 4
);
    // Handshakes: a requester raises REQ with DATA stable and holds both until a
    // one-cycle ACK; dropping REQ earlier withdraws it. TX_START is a one-cycle
    // valid for TX_DATA, issued only while TX_BUSY (the consumer's not-ready) is
    // low. F_SAVE/F_POP/F_RESET are one-cycle strobes issued only while F_BUSY=0.
    logic [STACK_WIDTH-1:0] A_DATA;
    logic                   A_REQ;
    logic                   A_ACK;
    logic [STACK_WIDTH-1:0] B_DATA;
    logic                   B_REQ;
    logic                   B_ACK;
    logic                   FLUSH;
    logic [STACK_WIDTH-1:0] TX_DATA;
    logic                   TX_START;
    logic                   TX_BUSY;
    logic [STACK_WIDTH-1:0] F_I_DATA;
    logic                   F_SAVE;
    logic                   F_POP;
    logic                   F_RESET;
    logic [STACK_WIDTH-1:0] F_O_DATA;
    logic                   F_FULL;
    logic                   F_EMPTY;
    logic                   F_BUSY;
    logic [LEVEL_W-1:0]     LEVEL;

    modport master (
        input  A_DATA, A_REQ, B_DATA, B_REQ, FLUSH, TX_BUSY,
        input  F_O_DATA, F_FULL, F_EMPTY, F_BUSY,
        output A_ACK, B_ACK, TX_DATA, TX_START,
        output F_I_DATA, F_SAVE, F_POP, F_RESET, LEVEL
    );

    modport slave (
        output A_DATA, A_REQ, B_DATA, B_REQ, FLUSH, TX_BUSY,
        output F_O_DATA, F_FULL, F_EMPTY, F_BUSY,
        input  A_ACK, B_ACK, TX_DATA, TX_START,
        input  F_I_DATA, F_SAVE, F_POP, F_RESET, LEVEL
    );
endinterface

// File: rtl/fifo_stack_sched.sv
// Round-robin scheduler sharing one fifo_stack between writers A/B and a byte
// transmitter; one stack operation in flight at a time, with flush priority.
module fifo_stack_sched #(
    parameter int STACK_SIZE  = 15,
    parameter int STACK_WIDTH = 8,
    parameter int LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               rstn,
    fifo_stack_sched_if.master bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_OP, S_GUARD, S_WAIT} state_t;
    typedef enum logic [1:0] {SEL_A, SEL_B, SEL_RD, SEL_FL} sel_t;

    state_t state_q, state_nx;
    sel_t   rr_ptr_q, op_sel_q, win_sel;
    logic   flush_pend_q;
    logic   elig_a, elig_b, elig_rd, win_valid, issue;

    logic [STACK_WIDTH-1:0] f_i_data_q;
    logic [STACK_WIDTH-1:0] tx_data_q;
    logic [LEVEL_W-1:0]     level_q;

    function automatic sel_t next_ptr(input sel_t s);
        case (s)
            SEL_A:   next_ptr = SEL_B;
            SEL_B:   next_ptr = SEL_RD;
            default: next_ptr = SEL_A;
        endcase
    endfunction

    // Arbitration: flush first, then round-robin starting at the pointer.
    always_comb begin
        elig_a    = bus.A_REQ && !bus.F_FULL;
        elig_b    = bus.B_REQ && !bus.F_FULL;
        elig_rd   = !bus.F_EMPTY && !bus.TX_BUSY;
        win_valid = 1'b0;
        win_sel   = SEL_A;
        if (flush_pend_q) begin
            win_valid = 1'b1;
            win_sel   = SEL_FL;
        end else begin
            case (rr_ptr_q)
                SEL_A: begin
                    if (elig_a)       begin win_valid = 1'b1; win_sel = SEL_A;  end
                    else if (elig_b)  begin win_valid = 1'b1; win_sel = SEL_B;  end
                    else if (elig_rd) begin win_valid = 1'b1; win_sel = SEL_RD; end
                end
                SEL_B: begin
                    if (elig_b)       begin win_valid = 1'b1; win_sel = SEL_B;  end
                    else if (elig_rd) begin win_valid = 1'b1; win_sel = SEL_RD; end
                    else if (elig_a)  begin win_valid = 1'b1; win_sel = SEL_A;  end
                end
                default: begin
                    if (elig_rd)      begin win_valid = 1'b1; win_sel = SEL_RD; end
                    else if (elig_a)  begin win_valid = 1'b1; win_sel = SEL_A;  end
                    else if (elig_b)  begin win_valid = 1'b1; win_sel = SEL_B;  end
                end
            endcase
        end
        issue = (state_q == S_IDLE) && !bus.F_BUSY && !bus.TX_START && win_valid;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_nx = S_OP;
            S_OP:    state_nx = S_GUARD;
            S_GUARD: state_nx = S_WAIT;
            S_WAIT:  if (!bus.F_BUSY) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.A_ACK    = 1'b0;
        bus.B_ACK    = 1'b0;
        bus.F_SAVE   = 1'b0;
        bus.F_POP    = 1'b0;
        bus.F_RESET  = 1'b0;
        bus.TX_START = 1'b0;
        if (state_q == S_OP) begin
            case (op_sel_q)
                SEL_A:   begin bus.A_ACK = 1'b1; bus.F_SAVE = 1'b1; end
                SEL_B:   begin bus.B_ACK = 1'b1; bus.F_SAVE = 1'b1; end
                SEL_RD:  begin bus.F_POP = 1'b1; bus.TX_START = 1'b1; end
                default: bus.F_RESET = 1'b1;
            endcase
        end
    end

    // Data for the OP cycle is captured on entry so the stack sees it with the strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q     <= SEL_A;
            op_sel_q     <= SEL_A;
            flush_pend_q <= 1'b0;
            f_i_data_q   <= '0;
            tx_data_q    <= '0;
            level_q      <= '0;
        end else begin
            if (issue) begin
                op_sel_q <= win_sel;
                if (win_sel != SEL_FL) rr_ptr_q <= next_ptr(win_sel);
                case (win_sel)
                    SEL_A:   f_i_data_q <= bus.A_DATA;
                    SEL_B:   f_i_data_q <= bus.B_DATA;
                    SEL_RD:  tx_data_q  <= bus.F_O_DATA;
                    default: ;
                endcase
            end
            if (state_q == S_OP) begin
                case (op_sel_q)
                    SEL_A, SEL_B: if (level_q != LEVEL_W'(STACK_SIZE)) level_q <= level_q + LEVEL_W'(1);
                    SEL_RD:       if (level_q != '0) level_q <= level_q - LEVEL_W'(1);
                    default:      level_q <= '0;
                endcase
            end
            if (bus.FLUSH) begin
                flush_pend_q <= 1'b1;
            end else if (state_q == S_OP && op_sel_q == SEL_FL) begin
                flush_pend_q <= 1'b0;
            end
        end
    end

    assign bus.F_I_DATA = f_i_data_q;
    assign bus.TX_DATA  = tx_data_q;
    assign bus.LEVEL    = level_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fifo_stack_sched.sv
// Directed bench for fifo_stack_sched with a behavioural FIFO standing in for the
// stack and an expected-byte queue checking everything handed to the transmitter.
module tb_fifo_stack_sched;
  localparam int W     = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 15;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;

  fifo_stack_sched_if #(.STACK_WIDTH(W), .LEVEL_W(LW)) ifc();

  fifo_stack_sched #(.STACK_SIZE(DEPTH), .STACK_WIDTH(W), .LEVEL_W(LW)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(ifc),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stack model: busy for 2 cycles after every strobe ----------------
  logic [W-1:0] stk_q[$];
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (ifc.F_RESET) stk_q.delete();
    else if (ifc.F_SAVE && stk_q.size() < DEPTH) stk_q.push_back(ifc.F_I_DATA);
    else if (ifc.F_POP && stk_q.size() > 0) stk_q.delete(0);
    if (ifc.F_SAVE || ifc.F_POP || ifc.F_RESET) busy_cnt = 2;
    else if (busy_cnt > 0) busy_cnt--;
    ifc.F_BUSY   <= (busy_cnt > 0);
    ifc.F_FULL   <= (stk_q.size() == DEPTH);
    ifc.F_EMPTY  <= (stk_q.size() == 0);
    ifc.F_O_DATA <= (stk_q.size() > 0) ? stk_q[0] : '0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [7:0]    ack_log[$];
  logic [LW-1:0] level_log[$];
  int cyc = 0, a_ack_cnt = 0, b_ack_cnt = 0, save_cnt = 0, pop_cnt = 0, reset_cnt = 0, tx_cnt = 0;
  int strobe_err = 0, pop_empty_err = 0, last_save = -1, min_gap = 1000;
  logic save_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (ifc.A_ACK) begin a_ack_cnt++; ack_log.push_back(8'h0A); end
      if (ifc.B_ACK) begin b_ack_cnt++; ack_log.push_back(8'h0B); end
      if (save_d) level_log.push_back(ifc.LEVEL);
      save_d = ifc.F_SAVE;
      if (ifc.F_SAVE) begin
        if (last_save >= 0 && cyc - last_save < min_gap) min_gap = cyc - last_save;
        last_save = cyc;
        save_cnt++;
      end
      if (ifc.F_POP) begin
        pop_cnt++;
        if (ifc.F_EMPTY) pop_empty_err++;
      end
      if (ifc.F_RESET) reset_cnt++;
      if (int'(ifc.F_SAVE) + int'(ifc.F_POP) + int'(ifc.F_RESET) > 1) strobe_err++;
      if (ifc.TX_START) begin
        tx_cnt++;
        if (exp_q.size() == 0) check("tx_unexpected_byte", {24'd0, ifc.TX_DATA}, 32'hFFFF_FFFF);
        else check("tx_data", {24'd0, ifc.TX_DATA}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_req(input bit sel_b, input logic [W-1:0] d);
    bit seen = 1'b0;
    if (sel_b) begin ifc.B_DATA = d; ifc.B_REQ = 1'b1; end
    else begin ifc.A_DATA = d; ifc.A_REQ = 1'b1; end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = sel_b ? ifc.B_ACK : ifc.A_ACK;
    end
    if (sel_b) ifc.B_REQ = 1'b0;
    else ifc.A_REQ = 1'b0;
    if (seen) exp_q.push_back(d);
    check(sel_b ? "b_ack_seen" : "a_ack_seen", {31'd0, seen}, 32'd1);
  endtask

  // Returns inside the OP cycle of the read, with TX_BUSY raised again.
  task automatic read_one();
    bit seen = 1'b0;
    ifc.TX_BUSY = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ifc.TX_START;
    end
    ifc.TX_BUSY = 1'b1;
    check("tx_start_seen", {31'd0, seen}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int base_a, base_save, base_rst, base_tx, rst_at_b;
  bit seen;

  initial begin
    ifc.A_REQ = 1'b1; ifc.A_DATA = 8'h11;
    ifc.B_REQ = 1'b0; ifc.B_DATA = '0;
    ifc.FLUSH = 1'b0; ifc.TX_BUSY = 1'b1;
    rstn = 1'b0;

    // Reset held for 2 cycles with A already requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", {28'd0, ifc.LEVEL}, 32'd0);
    check("rst_strobes", {26'd0, ifc.A_ACK, ifc.B_ACK, ifc.TX_START, ifc.F_SAVE, ifc.F_POP, ifc.F_RESET}, 32'd0);
    check("rst_data", {16'd0, ifc.TX_DATA, ifc.F_I_DATA}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("first_ack_timing", {31'd0, ifc.A_ACK}, 32'd1);
    check("first_save_data", {24'd0, ifc.F_I_DATA}, 32'h11);
    if (ifc.A_ACK) exp_q.push_back(8'h11);
    ifc.A_REQ = 1'b0;
    idle(8);
    check("t1_level", {28'd0, ifc.LEVEL}, 32'd1);
    read_one();
    idle(8);
    check("t1_level_drained", {28'd0, ifc.LEVEL}, 32'd0);

    // Write fairness with both requesters held
    ack_log.delete(); level_log.delete(); min_gap = 1000; last_save = -1;
    fork
      begin write_req(1'b0, 8'h21); write_req(1'b0, 8'h22); end
      begin write_req(1'b1, 8'h31); write_req(1'b1, 8'h32); end
    join
    idle(8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ack_order%0d", i), (i < ack_log.size()) ? {24'd0, ack_log[i]} : 32'hFF,
            (i % 2 == 0) ? 32'h0A : 32'h0B);
      check($sformatf("level_step%0d", i), (i < level_log.size()) ? {28'd0, level_log[i]} : 32'hFF,
            32'(i + 1));
    end
    check("save_gap_ge5", {31'd0, (min_gap >= 5)}, 32'd1);
    repeat (4) begin read_one(); idle(8); end
    check("t2_level_drained", {28'd0, ifc.LEVEL}, 32'd0);

    // Full stack: writes skipped until a read frees a row
    for (int i = 1; i <= 15; i++) write_req(1'b0, W'(i));
    idle(8);
    check("full_level", {28'd0, ifc.LEVEL}, 32'd15);
    base_a = a_ack_cnt; base_save = save_cnt;
    ifc.A_DATA = 8'h40; ifc.A_REQ = 1'b1;
    idle(50);
    check("full_no_ack", 32'(a_ack_cnt), 32'(base_a));
    check("full_no_save", 32'(save_cnt), 32'(base_save));
    read_one();
    check("full_first_tx", {24'd0, ifc.TX_DATA}, 32'h01);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ifc.A_ACK;
    end
    ifc.A_REQ = 1'b0;
    if (seen) exp_q.push_back(8'h40);
    check("full_late_ack", {31'd0, seen}, 32'd1);
    idle(8);
    check("full_level_after", {28'd0, ifc.LEVEL}, 32'd15);

    // Plain flush from idle
    base_rst = reset_cnt;
    ifc.FLUSH = 1'b1; @(posedge clk); #1; ifc.FLUSH = 1'b0;
    idle(8);
    exp_q.delete();
    check("flush_level", {28'd0, ifc.LEVEL}, 32'd0);
    check("flush_count", 32'(reset_cnt), 32'(base_rst + 1));

    // Drain order and no pop on empty
    write_req(1'b0, 8'hA5); write_req(1'b0, 8'h3C); write_req(1'b0, 8'hFF);
    idle(8);
    base_tx = tx_cnt;
    repeat (3) begin read_one(); idle(2); end
    ifc.TX_BUSY = 1'b0;
    idle(20);
    ifc.TX_BUSY = 1'b1;
    check("drain_tx_count", 32'(tx_cnt), 32'(base_tx + 3));
    check("drain_level", {28'd0, ifc.LEVEL}, 32'd0);
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);

    // Flush pulsed twice while a read is in flight, B waiting
    for (int i = 0; i < 6; i++) write_req(1'b0, W'(8'h51 + i));
    idle(8);
    check("t5_level", {28'd0, ifc.LEVEL}, 32'd6);
    base_rst = reset_cnt;
    read_one();
    @(posedge clk); #1;
    check("t5_guard_level", {28'd0, ifc.LEVEL}, 32'd5);
    ifc.FLUSH = 1'b1; ifc.B_DATA = 8'h77; ifc.B_REQ = 1'b1;
    @(posedge clk); #1; ifc.FLUSH = 1'b0;
    @(posedge clk); #1; ifc.FLUSH = 1'b1;
    @(posedge clk); #1; ifc.FLUSH = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    rst_at_b = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ifc.B_ACK;
    end
    rst_at_b = reset_cnt;
    ifc.B_REQ = 1'b0;
    if (seen) exp_q.push_back(8'h77);
    check("t5_b_ack", {31'd0, seen}, 32'd1);
    check("t5_flush_before_b", 32'(rst_at_b), 32'(base_rst + 1));
    idle(10);
    check("t5_flush_once", 32'(reset_cnt), 32'(base_rst + 1));
    check("t5_level", {28'd0, ifc.LEVEL}, 32'd1);
    read_one();
    idle(8);

    // Withdrawn request while the stack is busy
    write_req(1'b1, 8'h66);
    @(posedge clk); #1;
    base_a = a_ack_cnt; base_save = save_cnt;
    ifc.A_DATA = 8'h99; ifc.A_REQ = 1'b1;
    @(posedge clk); #1;
    ifc.A_REQ = 1'b0;
    idle(20);
    check("withdraw_no_ack", 32'(a_ack_cnt), 32'(base_a));
    check("withdraw_no_save", 32'(save_cnt), 32'(base_save));
    check("withdraw_level", {28'd0, ifc.LEVEL}, 32'd1);
    read_one();
    idle(8);

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_level", {28'd0, ifc.LEVEL}, 32'd0);
    check("strobe_exclusive", 32'(strobe_err), 32'd0);
    check("no_pop_when_empty", 32'(pop_empty_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
